// File: rtl/sccb_write_arbiter_if.sv
// sccb_write_arbiter_if
// Bundles the two requester ports, the SCCB engine handshake and the
// status/statistics outputs of sccb_write_arbiter.
//   req{0,1}_valid/addr/data  -> arbiter     request payload, held until ready
//   req{0,1}_ready/done/err   <- arbiter     accept pulse, completion pulse, error
//   eng_start/addr/data/abort <- arbiter     engine launch, payload, timeout abort
//   eng_done/eng_nack         -> arbiter     engine completion and ack status
//   busy/tx_count/err_count   <- arbiter     status and statistics
// Modport slave is the arbiter's view; master is the surrounding logic's view.
interface sccb_write_arbiter_if;
  logic        req0_valid;
  logic [7:0]  req0_addr;
  logic [7:0]  req0_data;
  logic        req0_ready;
  logic        req0_done;
  logic        req0_err;
  logic        req1_valid;
  logic [7:0]  req1_addr;
  logic [7:0]  req1_data;
  logic        req1_ready;
  logic        req1_done;
  logic        req1_err;
  logic        eng_start;
  logic [7:0]  eng_addr;
  logic [7:0]  eng_data;
  logic        eng_abort;
  logic        eng_done;
  logic        eng_nack;
  logic        busy;
  logic [15:0] tx_count;
  logic [7:0]  err_count;

  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  eng_done, eng_nack,
    output req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err,
    output eng_start, eng_addr, eng_data, eng_abort, busy, tx_count, err_count
  );

  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output eng_done, eng_nack,
    input  req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err,
    input  eng_start, eng_addr, eng_data, eng_abort, busy, tx_count, err_count
  );
endinterface

// File: rtl/sccb_write_arbiter.sv
// sccb_write_arbiter
// Shares one SCCB byte-write engine between the power-up configuration
// sequencer (port 0) and runtime register tweaks (port 1). One write is in
// flight at a time; ties are broken round-robin. A timeout aborts a stuck
// engine and a minimum idle gap separates transactions.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  sccb_write_arbiter_if.slave (requesters, engine, status)
//
// state | meaning
// IDLE  | waiting for a request; grants on the next edge when any is valid
// WAIT  | write launched, waiting for eng_done or timeout
// GAP   | enforcing the bus-idle gap before the next grant
module sccb_write_arbiter #(
  parameter int GAP_CYCLES     = 1200,
  parameter int TIMEOUT_CYCLES = 24000
) (
  input logic                 clk,
  input logic                 rst,
  sccb_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (GAP_CYCLES < 3) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES);
  // GAP occupies GAP_CYCLES cycles (at least one), so the next grant edge
  // lands GAP_CYCLES+1 cycles after the done pulse.
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          owner_q, owner_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          ready0_q, ready0_d, ready1_q, ready1_d;
  logic          done0_q, done0_d, done1_q, done1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic          start_q, start_d, abort_q, abort_d;
  logic [7:0]    addr_q, addr_d, data_q, data_d;
  logic          busy_q, busy_d;
  logic [15:0]   tx_q, tx_d;
  logic [7:0]    errc_q, errc_d;
  logic          win, fin, fin_err;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    to_cnt_d     = to_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    addr_d       = addr_q;
    data_d       = data_q;
    ready0_d     = 1'b0;
    ready1_d     = 1'b0;
    start_d      = 1'b0;
    abort_d      = 1'b0;
    win          = 1'b0;
    fin          = 1'b0;
    fin_err      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          win          = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
          ready0_d     = ~win;
          ready1_d     = win;
          start_d      = 1'b1;
          addr_d       = win ? bus.req1_addr : bus.req0_addr;
          data_d       = win ? bus.req1_data : bus.req0_data;
          owner_d      = win;
          last_grant_d = win;
          to_cnt_d     = '0;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        // A completion on the timeout edge still counts as a completion.
        if (bus.eng_done) begin
          fin       = 1'b1;
          fin_err   = bus.eng_nack;
          gap_cnt_d = '0;
          state_d   = GAP;
        end else if (to_cnt_q == TO_LAST) begin
          fin       = 1'b1;
          fin_err   = 1'b1;
          abort_d   = 1'b1;
          gap_cnt_d = '0;
          state_d   = GAP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    done0_d = fin && !owner_q;
    done1_d = fin && owner_q;
    err0_d  = fin && fin_err && !owner_q;
    err1_d  = fin && fin_err && owner_q;
    tx_d    = fin ? tx_q + 16'd1 : tx_q;
    errc_d  = (fin && fin_err && errc_q != 8'hff) ? errc_q + 8'd1 : errc_q;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      to_cnt_q     <= '0;
      gap_cnt_q    <= '0;
      ready0_q     <= 1'b0;
      ready1_q     <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      start_q      <= 1'b0;
      abort_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      tx_q         <= '0;
      errc_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      to_cnt_q     <= to_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      ready0_q     <= ready0_d;
      ready1_q     <= ready1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      start_q      <= start_d;
      abort_q      <= abort_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      tx_q         <= tx_d;
      errc_q       <= errc_d;
    end
  end

  assign bus.req0_ready = ready0_q;
  assign bus.req1_ready = ready1_q;
  assign bus.req0_done  = done0_q;
  assign bus.req1_done  = done1_q;
  assign bus.req0_err   = err0_q;
  assign bus.req1_err   = err1_q;
  assign bus.eng_start  = start_q;
  assign bus.eng_abort  = abort_q;
  assign bus.eng_addr   = addr_q;
  assign bus.eng_data   = data_q;
  assign bus.busy       = busy_q;
  assign bus.tx_count   = tx_q;
  assign bus.err_count  = errc_q;

endmodule

// File: tb/tb_sccb_write_arbiter.sv
// tb_sccb_write_arbiter
// Scoreboard bench: each posted write pushes its expected grant/completion
// record; a monitor pops and compares on eng_start and on the done pulse.
module tb_sccb_write_arbiter;
  localparam int GAP = 20;
  localparam int TO  = 50;

  typedef struct { logic [7:0] addr; logic [7:0] data; } req_t;
  typedef struct { int delay; bit nack; } eng_t;
  typedef struct {
    bit port; logic [7:0] addr; logic [7:0] data; bit err; bit abort; int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  req_t rq0[$];
  req_t rq1[$];
  eng_t eng_q[$];
  exp_t start_q[$];
  exp_t cur;
  bit   cur_valid = 1'b0;
  int   cur_start = 0;
  bit   have_done = 1'b0;
  int   last_done = 0;
  logic [15:0] exp_tx = '0;
  logic [7:0]  exp_err = '0;

  sccb_write_arbiter_if sif();

  sccb_write_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic post(input bit port, input logic [7:0] a, input logic [7:0] d,
                      input int dly, input bit nk);
    req_t r; eng_t g; exp_t e;
    r.addr = a; r.data = d;
    if (port) rq1.push_back(r); else rq0.push_back(r);
    g.delay = dly; g.nack = nk;
    eng_q.push_back(g);
    e.port = port; e.addr = a; e.data = d;
    if (dly >= 0 && dly <= TO) begin
      e.err = nk; e.abort = 1'b0; e.lat = dly + 1;
    end else begin
      e.err = 1'b1; e.abort = 1'b1; e.lat = TO + 1;
    end
    start_q.push_back(e);
  endtask

  task automatic check_zero(input string p);
    chk({p, "_ready0"}, sif.req0_ready, 0);
    chk({p, "_ready1"}, sif.req1_ready, 0);
    chk({p, "_done"},   {sif.req0_done, sif.req1_done}, 0);
    chk({p, "_err"},    {sif.req0_err, sif.req1_err}, 0);
    chk({p, "_start"},  sif.eng_start, 0);
    chk({p, "_abort"},  sif.eng_abort, 0);
    chk({p, "_busy"},   sif.busy, 0);
    chk({p, "_addr"},   sif.eng_addr, 0);
    chk({p, "_data"},   sif.eng_data, 0);
    chk({p, "_tx"},     sif.tx_count, 0);
    chk({p, "_errc"},   sif.err_count, 0);
  endtask

  task automatic reset_assert();
    @(negedge clk);
    rst = 1'b1;
    #1;
    rq0.delete(); rq1.delete(); eng_q.delete(); start_q.delete();
    cur_valid = 1'b0; have_done = 1'b0; exp_tx = '0; exp_err = '0;
    check_zero("rst");
  endtask

  task automatic reset_release();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((start_q.size() != 0 || cur_valid || sif.busy) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drained", start_q.size() + int'(cur_valid) + int'(sif.busy), 0);
  endtask

  // requesters: present queue head, advance on ready
  initial begin
    sif.req0_valid = 0; sif.req0_addr = '0; sif.req0_data = '0;
    forever begin
      @(negedge clk);
      if (sif.req0_ready && rq0.size() > 0) void'(rq0.pop_front());
      sif.req0_valid = (rq0.size() > 0);
      if (rq0.size() > 0) begin sif.req0_addr = rq0[0].addr; sif.req0_data = rq0[0].data; end
    end
  end

  initial begin
    sif.req1_valid = 0; sif.req1_addr = '0; sif.req1_data = '0;
    forever begin
      @(negedge clk);
      if (sif.req1_ready && rq1.size() > 0) void'(rq1.pop_front());
      sif.req1_valid = (rq1.size() > 0);
      if (rq1.size() > 0) begin sif.req1_addr = rq1[0].addr; sif.req1_data = rq1[0].data; end
    end
  end

  // engine model: done after a scripted delay, negative delay = never
  initial begin
    eng_t g;
    sif.eng_done = 0; sif.eng_nack = 0;
    forever begin
      @(negedge clk);
      if (!rst && sif.eng_start) begin
        if (eng_q.size() > 0) g = eng_q.pop_front();
        else begin g.delay = -1; g.nack = 0; end
        if (g.delay >= 0) begin
          repeat (g.delay) @(negedge clk);
          sif.eng_done = 1; sif.eng_nack = g.nack;
          @(negedge clk);
          sif.eng_done = 0; sif.eng_nack = 0;
        end
      end
    end
  end

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sif.eng_start) begin
          if (start_q.size() == 0) chk("unexpected_start", sif.eng_start, 0);
          else begin
            cur = start_q.pop_front();
            cur_valid = 1'b1;
            cur_start = cyc;
            chk("ready0", sif.req0_ready, !cur.port);
            chk("ready1", sif.req1_ready, cur.port);
            chk("eng_addr", sif.eng_addr, cur.addr);
            chk("eng_data", sif.eng_data, cur.data);
            chk("busy_start", sif.busy, 1);
            if (have_done) chk("gap_ok", (cyc - last_done) >= GAP + 1, 1);
          end
        end else if (sif.req0_ready || sif.req1_ready) begin
          chk("stray_ready", sif.req0_ready | sif.req1_ready, 0);
        end
        if (sif.req0_done || sif.req1_done) begin
          if (!cur_valid) chk("unexpected_done", sif.req0_done | sif.req1_done, 0);
          else begin
            cur_valid = 1'b0;
            have_done = 1'b1;
            last_done = cyc;
            exp_tx = exp_tx + 16'd1;
            if (cur.err && exp_err != 8'hff) exp_err = exp_err + 8'd1;
            chk("done0", sif.req0_done, !cur.port);
            chk("done1", sif.req1_done, cur.port);
            chk("err0", sif.req0_err, !cur.port && cur.err);
            chk("err1", sif.req1_err, cur.port && cur.err);
            chk("abort", sif.eng_abort, cur.abort);
            chk("latency", cyc - cur_start, cur.lat);
            chk("tx_count", sif.tx_count, exp_tx);
            chk("err_count", sif.err_count, exp_err);
          end
        end else if (sif.eng_abort) begin
          chk("stray_abort", sif.eng_abort, 0);
        end
      end
    end
  end

  initial begin
    int n;
    // reset state
    reset_assert();
    reset_release();
    @(negedge clk); #1;
    check_zero("idle");

    // single write
    post(0, 8'h12, 8'h80, 10, 0);
    drain(500);
    chk("single_tx", sif.tx_count, 1);

    // tie and fairness from reset
    reset_assert();
    post(0, 8'h01, 8'hA0, 3, 0);
    post(1, 8'h11, 8'hB0, 5, 0);
    post(0, 8'h02, 8'hA1, 2, 0);
    post(1, 8'h12, 8'hB1, 7, 0);
    post(0, 8'h03, 8'hA2, 4, 0);
    post(1, 8'h13, 8'hB2, 1, 0);
    reset_release();
    drain(2000);
    chk("tie_tx", sif.tx_count, 6);

    // NACK on port 1
    reset_assert();
    reset_release();
    post(1, 8'h0A, 8'hFF, 4, 1);
    drain(500);
    chk("nack_errc", sif.err_count, 1);
    chk("nack_tx", sif.tx_count, 1);

    // timeout with a late done landing in GAP
    reset_assert();
    reset_release();
    post(0, 8'h21, 8'h44, 55, 0);
    drain(1000);
    chk("to_tx", sif.tx_count, exp_tx);
    chk("to_errc", sif.err_count, 1);

    // done on the timeout edge
    post(1, 8'h30, 8'h07, TO, 0);
    drain(1000);
    chk("sim_tx", sif.tx_count, 2);
    chk("sim_errc", sif.err_count, 1);

    // reset mid-WAIT
    post(0, 8'h5A, 8'h33, -1, 0);
    n = 0;
    while (!cur_valid && n < 200) begin @(negedge clk); #1; n++; end
    chk("midwait_started", cur_valid, 1);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero("midrst");
    rq0.delete(); rq1.delete(); eng_q.delete(); start_q.delete();
    cur_valid = 1'b0; have_done = 1'b0; exp_tx = '0; exp_err = '0;
    reset_release();
    repeat (TO + 5) @(negedge clk);
    #1;
    chk("midrst_quiet_tx", sif.tx_count, 0);
    post(0, 8'h66, 8'h77, 6, 0);
    drain(500);
    chk("midrst_tx", sif.tx_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sccb_write_arbiter.md
# sccb_write_arbiter

Shares one SCCB byte-write engine between two requesters: the power-up camera configuration sequencer (port 0) and runtime register adjustment logic such as exposure/gain tweaks (port 1). It accepts one register write at a time and launches it on the engine with a start/done handshake. It enforces a minimum bus-idle gap between transactions and a completion timeout. Completion, error and statistics are reported back per requester.

## Interface
Parameters:
- GAP_CYCLES, 1200: idle cycles after each transaction before the next grant (100 us at 12 MHz).
- TIMEOUT_CYCLES, 24000: maximum cycles from eng_start to eng_done before abort (2 ms at 12 MHz).

Ports:
- clk  in  1  system clock, 12 MHz.
- rst  in  1  asynchronous, active-high reset.
- req0_valid, req1_valid  in  1  write request pending. Held with stable addr/data until the matching ready.
- req0_addr, req1_addr  in  8  camera register address.
- req0_data, req1_data  in  8  register value.
- req0_ready, req1_ready  out  1  one-cycle accept pulse.
- req0_done, req1_done  out  1  one-cycle completion pulse.
- req0_err, req1_err  out  1  qualifies done: 1 = NACK or timeout.
- eng_start  out  1  one-cycle launch pulse to the engine.
- eng_addr, eng_data  out  8  latched write payload, stable from eng_start until eng_done.
- eng_abort  out  1  one-cycle pulse on timeout, forcing the engine back to idle.
- eng_done  in  1  one-cycle engine completion pulse.
- eng_nack  in  1  sampled with eng_done; 1 = slave did not acknowledge.
- busy  out  1  high in any state other than IDLE.
- tx_count  out  16  transactions completed, wraps at 65535 -> 0.
- err_count  out  8  errored transactions, saturates at 255.

## Operation
- States: IDLE, WAIT, GAP. All outputs are registered.
- IDLE, no valid: stay in IDLE.
- IDLE, one or both valid: the next edge performs all of the following.
  - Choose a winner. A single valid wins outright. With both valid, the port not granted last wins.
  - Set reqN_ready=1 and eng_start=1 for exactly one cycle.
  - Latch addr/data into eng_addr/eng_data and record the owner.
  - Update last_grant; clear the timeout counter; go to WAIT.
- WAIT, normal completion: count cycles since eng_start. On eng_done, pulse owner done=1 and err=eng_nack for one cycle, then go to GAP.
- WAIT, timeout: when the count reaches TIMEOUT_CYCLES without eng_done, pulse eng_abort, owner done=1 and err=1, then go to GAP.
- WAIT, done and timeout on the same edge: eng_done wins, and err=eng_nack.
- Outside WAIT: eng_done is ignored and does not change counters or pulses.
- GAP: count GAP_CYCLES, then return to IDLE. Requests arriving in GAP wait; ready is never asserted outside the IDLE->WAIT edge.
- Counters:
  - tx_count increments on every done pulse, errored or not.
  - err_count increments on every done pulse with err=1.
- Round-robin state: last_grant resets to 1, so port 0 wins the first tie.
- Requesters must not drop valid before ready. A dropped request is simply not served and raises no error.

## Timing
- Reset (asynchronous, immediate): state=IDLE and last_grant=1. All of the following are 0: ready, done, err, eng_start, eng_abort, busy, eng_addr, eng_data, tx_count, err_count and both internal counters. Reset in WAIT issues no eng_abort and no done pulse.
- Accept latency: valid seen in IDLE on edge k means ready and eng_start are high in cycle k+1, and busy rises in the same cycle.
- eng_done in cycle m means done/err are high in cycle m+1 and state=GAP.
- Gap timing:
  - With GAP_CYCLES=G, the earliest next eng_start is G+1 cycles after the done pulse cycle.
  - G=0 means GAP lasts one cycle.
- Timeout: eng_abort, done and err are asserted in cycle eng_start+TIMEOUT_CYCLES+1.
- Back-to-back: a requester holding valid continuously after its ready is re-granted only after GAP. If the other port is valid, the other port wins instead.

## Test plan
- Single write: req0 valid, addr=0x12, data=0x80; engine returns done 10 cycles after start with nack=0. Required: one ready, one eng_start with eng_addr=0x12 and eng_data=0x80, req0_done=1 with req0_err=0, tx_count=1.
- Tie and fairness: both ports valid from reset, each with 3 writes queued. Required: grant order 0,1,0,1,0,1, and consecutive eng_start pulses separated by at least GAP+1 cycles after each done.
- NACK: engine returns done with nack=1. Required: req1_err=1 with req1_done, err_count=1, tx_count=1.
- Timeout: TIMEOUT_CYCLES=50 and the engine never answers. Required: eng_abort and req0_done/err high 51 cycles after eng_start. A late eng_done arriving in GAP is ignored.
- Simultaneous done and timeout on the same edge with nack=0: required err=0 and no eng_abort.
- Reset mid-WAIT: required all outputs 0 immediately, no done pulse, and the next request accepted normally with tx_count restarting at 1.
